blink_bank: RTL and testbench

Multi-channel successor to the single-output blinker. It drives `CHANNELS` LED outputs from one shared prescaler. Each channel independently selects off, on, continuous blink, or a counted burst with a start/busy/done handshake. It sits directly at the board top level between the clock pin and the LED pins.

---
 rtl/blink_bank.sv | 226 ++++++++++++++++++++++
 tb/tb_blink_bank.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_bank.sv
`default_nettype none
// ============================================================================
//  Module   : blink_bank
//  Purpose  : Multi-channel LED driver sharing a single prescaler. Each
//             channel selects off, on, continuous blink, or a counted
//             burst with a start/busy/done handshake. Because the prescaler
//             is shared, every blinking or bursting channel is phase-aligned.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FREQ     : input clock frequency in Hz (must be non-zero)
//    SECS     : blink period in seconds (must be non-zero)
//    CHANNELS : number of LED channels, 1..32
//    BURST    : on-pulses per burst, 1..255
//  Ports
//    clk_i    : in  1            rising-edge clock
//    rst_ni   : in  1            synchronous active-low reset
//    mode_i   : in  2*CHANNELS   channel c mode at [2c+1:2c]
//                                00 off, 01 on, 10 blink, 11 burst
//    start_i  : in  CHANNELS     per-channel burst start (level-sampled)
//    led_o    : out CHANNELS     registered LED drives
//    busy_o   : out CHANNELS     burst in progress
//    done_o   : out CHANNELS     one-cycle burst-complete pulse
// ============================================================================
module blink_bank #(
  parameter int FREQ     = 0,
  parameter int SECS     = 0,
  parameter int CHANNELS = 4,
  parameter int BURST    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [2*CHANNELS-1:0] mode_i,
  input  logic [CHANNELS-1:0]   start_i,
  output logic [CHANNELS-1:0]   led_o,
  output logic [CHANNELS-1:0]   busy_o,
  output logic [CHANNELS-1:0]   done_o
);

  // Half-period in clock cycles.
  localparam int DIV = (FREQ * SECS) / 2;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = (BURST > 0) ? $clog2(BURST + 1) : 1;

  localparam logic [PW-1:0] C_DIV_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] C_BURST    = CW'(BURST);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  // --------------------------------------------------------------------------
  // Parameter sanity: a bad configuration must never reach silicon.
  // --------------------------------------------------------------------------
  if (FREQ <= 0 || SECS <= 0 || (FREQ * SECS) < 2) begin : g_bad_timing
    $error("blink_bank: FREQ and SECS must be set and FREQ*SECS must be >= 2");
  end
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("blink_bank: CHANNELS must be in 1..32");
  end
  if (BURST < 1 || BURST > 255) begin : g_bad_burst
    $error("blink_bank: BURST must be in 1..255");
  end

  // --------------------------------------------------------------------------
  // Shared prescaler. w_tick marks the last cycle of each half-period; all
  // channels act on the edge that ends that cycle.
  // --------------------------------------------------------------------------
  logic [PW-1:0] r_pcnt;
  logic          w_tick;

  assign w_tick = (r_pcnt == C_DIV_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel logic. The burst FSM only advances while the channel is in
  // burst mode; any other mode forces it back to IDLE, which is what aborts
  // a burst in flight without raising done.
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [1:0]    w_mode;
    logic          w_start;
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_led;
    logic          w_led_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_done;
    logic          w_done_nxt;

    assign w_mode  = mode_i[2*c +: 2];
    assign w_start = start_i[c];

    // State register, together with the registered channel outputs so that
    // every output changes exactly one edge after its cause.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_led   <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_led   <= w_led_nxt;
        r_busy  <= w_busy_nxt;
        r_done  <= w_done_nxt;
      end
    end

    // Next-state logic.
    always_comb begin
      w_state_nxt = r_state;
      if (w_mode != MODE_BURST) begin
        w_state_nxt = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              w_state_nxt = S_ARM;
            end
          end
          S_ARM: begin
            if (w_tick) begin
              w_state_nxt = S_RUN;
            end
          end
          S_RUN: begin
            // The final falling edge of the last pulse ends the burst.
            if (w_tick && r_led && (r_cnt == C_BURST)) begin
              w_state_nxt = S_IDLE;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
          end
        endcase
      end
    end

    // Output logic: next values of the registered channel outputs.
    always_comb begin
      w_led_nxt  = r_led;
      w_cnt_nxt  = r_cnt;
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      case (w_mode)
        MODE_OFF: begin
          w_led_nxt = 1'b0;
          w_cnt_nxt = '0;
        end
        MODE_ON: begin
          w_led_nxt = 1'b1;
          w_cnt_nxt = '0;
        end
        MODE_BLINK: begin
          // Holds whatever level it had until the first shared tick.
          if (w_tick) begin
            w_led_nxt = ~r_led;
          end
          w_cnt_nxt = '0;
        end
        default: begin
          case (r_state)
            S_IDLE: begin
              w_led_nxt  = 1'b0;
              w_cnt_nxt  = '0;
              w_busy_nxt = w_start;
            end
            S_ARM: begin
              w_busy_nxt = 1'b1;
              if (w_tick) begin
                w_led_nxt = 1'b1;
                w_cnt_nxt = C_CNT_ONE;
              end
            end
            S_RUN: begin
              w_busy_nxt = 1'b1;
              if (w_tick) begin
                if (r_led) begin
                  w_led_nxt = 1'b0;
                  if (r_cnt == C_BURST) begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                  end
                end else begin
                  w_led_nxt = 1'b1;
                  w_cnt_nxt = r_cnt + 1'b1;
                end
              end
            end
            default: begin
              w_led_nxt = 1'b0;
              w_cnt_nxt = '0;
            end
          endcase
        end
      endcase
    end

    assign led_o[c]  = r_led;
    assign busy_o[c] = r_busy;
    assign done_o[c] = r_done;
  end

endmodule
`default_nettype wire

// File: tb/tb_blink_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blink_bank
//  Purpose  : Directed self-checking bench for blink_bank with FREQ=8,
//             SECS=1 (DIV=4), CHANNELS=4, BURST=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_blink_bank;

  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] mode_i = 8'hAA;
  logic [3:0] start_i = 4'h0;
  logic [3:0] led_o;
  logic [3:0] busy_o;
  logic [3:0] done_o;

  int tests = 0;
  int fails = 0;
  int ncyc  = 0;   // edges since the last reset release

  blink_bank #(
    .FREQ    (8),
    .SECS    (1),
    .CHANNELS(4),
    .BURST   (3)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .mode_i (mode_i),
    .start_i(start_i),
    .led_o  (led_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    ncyc++;
  endtask

  // Watches channel 0 until its burst completes (or a cycle budget runs
  // out) and returns what it saw. Optionally re-pulses start_i[0] at step
  // second_at to exercise the ignore-while-busy rule.
  task automatic observe_burst(input int second_at,
                               output int pulses, output int dones,
                               output int first_rise, output int done_at,
                               output int bad_len, output int busy1_seen,
                               output logic [1:0] done_lb,
                               output logic timed_out);
    logic prev;
    int   len;
    pulses = 0; dones = 0; first_rise = -1; done_at = -1;
    bad_len = 0; busy1_seen = 0; done_lb = 2'b11; timed_out = 1'b1;
    prev = 1'b0; len = 0;
    for (int k = 1; k <= 60; k++) begin
      start_i[0] = (k == second_at);
      step();
      if (busy_o[1]) busy1_seen++;
      if (led_o[0] && !prev) begin
        pulses++;
        if (pulses == 1) first_rise = ncyc;
        len = 0;
      end
      if (led_o[0]) len++;
      if (!led_o[0] && prev && len != 4) bad_len++;
      if (done_o[0]) begin
        dones++;
        done_at = ncyc;
        done_lb = {led_o[0], busy_o[0]};
      end
      prev = led_o[0];
      if (!busy_o[0]) begin
        timed_out = 1'b0;
        break;
      end
    end
    start_i[0] = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_ni = 1'b0; mode_i = 8'hAA; start_i = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({led_o, busy_o, done_o} !== 12'h000) begin
        fails++;
        $display("FAIL reset_hold cycle %0d: led=%b busy=%b done=%b, want all 0",
                 i, led_o, busy_o, done_o);
      end
    end
    rst_ni = 1'b1;
    ncyc = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = (i == 4) ? 4'hF : 4'h0;
      tests++;
      if (led_o !== exp || busy_o !== 4'h0 || done_o !== 4'h0) begin
        fails++;
        $display("FAIL first_toggle edge %0d: led=%b busy=%b done=%b, want led=%b busy=0 done=0",
                 i, led_o, busy_o, done_o, exp);
      end
    end
  endtask

  task automatic test_blink();
    logic e;
    e = 1'b1;   // all LEDs went high on edge 4
    for (int i = 0; i < 16; i++) begin
      step();
      if (ncyc % 4 == 0) e = ~e;
      tests++;
      if (led_o !== {4{e}}) begin
        fails++;
        $display("FAIL blink_all edge %0d: led=%b, want %b", ncyc, led_o, {4{e}});
      end
    end
    mode_i = 8'h9A;   // channel 2 on
    for (int i = 0; i < 4; i++) begin
      step();
      if (ncyc % 4 == 0) e = ~e;
      tests++;
      if (led_o !== {e, 1'b1, e, e}) begin
        fails++;
        $display("FAIL blink_ch2_on edge %0d: led=%b, want %b", ncyc, led_o, {e, 1'b1, e, e});
      end
    end
    mode_i = 8'h8A;   // channel 2 off
    for (int i = 0; i < 4; i++) begin
      step();
      if (ncyc % 4 == 0) e = ~e;
      tests++;
      if (led_o !== {e, 1'b0, e, e}) begin
        fails++;
        $display("FAIL blink_ch2_off edge %0d: led=%b, want %b", ncyc, led_o, {e, 1'b0, e, e});
      end
    end
    mode_i = 8'hAA;
  endtask

  task automatic test_burst();
    int n0, m, pulses, dones, first_rise, done_at, bad_len, b1;
    logic [1:0] done_lb;
    logic to;
    mode_i = 8'hAB;   // channel 0 burst, others blink
    step();
    tests++;
    if (led_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL burst_idle: led0=%b busy0=%b, want 0 0", led_o[0], busy_o[0]);
    end
    start_i = 4'b0001;
    step();
    n0 = ncyc;
    start_i = 4'b0000;
    tests++;
    if (busy_o[0] !== 1'b1 || led_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL burst_busy_rise: busy0=%b led0=%b, want 1 0", busy_o[0], led_o[0]);
    end
    m = n0;
    while (m % 4 != 3) m++;
    observe_burst(0, pulses, dones, first_rise, done_at, bad_len, b1, done_lb, to);
    tests++;
    if (to !== 1'b0) begin
      fails++;
      $display("FAIL burst_timeout: busy0 never fell, want fall within 60 cycles");
    end
    tests++;
    if (pulses != 3 || dones != 1) begin
      fails++;
      $display("FAIL burst_counts: pulses=%0d dones=%0d, want 3 1", pulses, dones);
    end
    tests++;
    if (first_rise != m + 1 || done_at != m + 21) begin
      fails++;
      $display("FAIL burst_timing: first_rise=%0d done_at=%0d, want %0d %0d",
               first_rise, done_at, m + 1, m + 21);
    end
    tests++;
    if (bad_len != 0 || done_lb !== 2'b00) begin
      fails++;
      $display("FAIL burst_shape: bad_pulse_len=%0d led/busy at done=%b, want 0 00",
               bad_len, done_lb);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || led_o[0] !== 1'b0) begin
        fails++;
        $display("FAIL burst_after: done0=%b busy0=%b led0=%b, want 0 0 0",
                 done_o[0], busy_o[0], led_o[0]);
      end
    end
  endtask

  task automatic test_ignored_starts();
    int pulses, dones, first_rise, done_at, bad_len, b1;
    logic [1:0] done_lb;
    logic to;
    start_i = 4'b0011;   // channel 1 is in blink mode
    step();
    start_i = 4'b0010;
    tests++;
    if (busy_o[0] !== 1'b1 || busy_o[1] !== 1'b0) begin
      fails++;
      $display("FAIL ignored_start_accept: busy=%b, want bit0=1 bit1=0", busy_o);
    end
    observe_burst(8, pulses, dones, first_rise, done_at, bad_len, b1, done_lb, to);
    start_i = 4'b0000;
    tests++;
    if (to !== 1'b0 || pulses != 3 || dones != 1) begin
      fails++;
      $display("FAIL ignored_restart: timeout=%b pulses=%0d dones=%0d, want 0 3 1",
               to, pulses, dones);
    end
    tests++;
    if (b1 != 0) begin
      fails++;
      $display("FAIL ignored_ch1_busy: busy1 high %0d cycles, want 0", b1);
    end
    step();
  endtask

  task automatic test_abort();
    int falls;
    logic prev;
    logic bad;
    falls = 0; prev = 1'b0; bad = 1'b0;
    start_i = 4'b0001;
    step();
    start_i = 4'b0000;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!led_o[0] && prev) falls++;
      prev = led_o[0];
      if (falls == 2) break;
    end
    tests++;
    if (falls != 2 || busy_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL abort_setup: falls=%0d busy0=%b, want 2 1", falls, busy_o[0]);
    end
    mode_i = 8'hA8;   // channel 0 off
    step();
    tests++;
    if (busy_o[0] !== 1'b0 || led_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort_mode: busy0=%b led0=%b done0=%b, want 0 0 0",
               busy_o[0], led_o[0], done_o[0]);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (done_o[0] || busy_o[0]) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL abort_quiet: saw done0/busy0 after abort=%b, want 0", bad);
    end
  endtask

  task automatic test_reset_abort();
    int rises;
    logic prev;
    logic bad;
    rises = 0; prev = 1'b0; bad = 1'b0;
    mode_i = 8'hAB;
    step();
    start_i = 4'b0001;
    step();
    start_i = 4'b0000;
    for (int i = 0; i < 60; i++) begin
      step();
      if (led_o[0] && !prev) rises++;
      prev = led_o[0];
      if (rises == 3) break;
    end
    tests++;
    if (rises != 3 || busy_o[0] !== 1'b1 || led_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL rstabort_setup: rises=%0d busy0=%b led0=%b, want 3 1 1",
               rises, busy_o[0], led_o[0]);
    end
    rst_ni = 1'b0;
    step();
    tests++;
    if (led_o !== 4'h0 || busy_o !== 4'h0 || done_o !== 4'h0) begin
      fails++;
      $display("FAIL rstabort_clear: led=%b busy=%b done=%b, want all 0",
               led_o, busy_o, done_o);
    end
    rst_ni = 1'b1;
    ncyc = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (done_o[0] || busy_o[0]) bad = 1'b1;
      if (i == 4) begin
        tests++;
        if (led_o !== 4'b1110) begin
          fails++;
          $display("FAIL rstabort_restart: led=%b at edge 4, want 1110", led_o);
        end
      end
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL rstabort_quiet: saw done0/busy0 after reset=%b, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_burst();
    test_ignored_starts();
    test_abort();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
